// File: rtl/spi_bus_arbiter.sv
// Arbitrates the shared SPI bus between the gain, ADC and DAC engines.
// Gain has fixed priority, ADC/DAC share a round-robin slot, grants time out and are followed by a fixed idle gap.
module spi_bus_arbiter #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic req_gain,
    input  logic req_adc,
    input  logic req_dac,
    input  logic done_gain,
    input  logic done_adc,
    input  logic done_dac,
    output logic enablegain,
    output logic enableadc,
    output logic enabledac,
    output logic spissb,
    output logic sf_ce0,
    output logic fpgainitb,
    output logic busy,
    output logic timeout_err
);

    // state    | meaning
    // ST_IDLE  | bus free, requests sampled every clock
    // ST_GRANT | one engine owns the bus, hold counter running
    // ST_GAP   | bus quiet for GAP clocks, requests ignored
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  GAP_LOAD  = 4'(GAP - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  en_q, en_d;          // bit0 gain, bit1 adc, bit2 dac
    logic [15:0] hold_q, hold_d;
    logic [3:0]  gap_q, gap_d;
    logic        rr_q, rr_d;          // 0 selects ADC, 1 selects DAC
    logic        busy_q, busy_d;
    logic        tmo_q, tmo_d;
    logic [2:0]  desel_q, desel_d;

    logic [2:0] req_v;
    logic [2:0] done_v;
    logic       own_req;
    logic       own_done;
    logic       grant_end;

    assign req_v    = {req_dac, req_adc, req_gain};
    assign done_v   = {done_dac, done_adc, done_gain};
    assign own_req  = |(en_q & req_v);
    assign own_done = |(en_q & done_v);

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        rr_d      = rr_q;
        tmo_d     = 1'b0;
        desel_d   = 3'b111;
        grant_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_v) begin
                    state_d = ST_GRANT;
                    hold_d  = 16'd0;
                    if (req_gain)
                        en_d = 3'b001;
                    else if (req_adc && req_dac)
                        en_d = rr_q ? 3'b100 : 3'b010;
                    else if (req_adc)
                        en_d = 3'b010;
                    else
                        en_d = 3'b100;
                end
            end
            ST_GRANT: begin
                // A normal end outranks a timeout landing on the same clock.
                if (own_done || !own_req) begin
                    grant_end = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    grant_end = 1'b1;
                    tmo_d     = 1'b1;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
                if (grant_end) begin
                    state_d = ST_GAP;
                    en_d    = 3'b000;
                    gap_d   = GAP_LOAD;
                    if (en_q[1])
                        rr_d = 1'b1;
                    else if (en_q[2])
                        rr_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0)
                    state_d = ST_IDLE;
                else
                    gap_d = gap_q - 4'd1;
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 3'b000;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            en_q    <= 3'b000;
            hold_q  <= 16'd0;
            gap_q   <= 4'd0;
            rr_q    <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            desel_q <= 3'b111;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            desel_q <= desel_d;
        end
    end

    assign enablegain  = en_q[0];
    assign enableadc   = en_q[1];
    assign enabledac   = en_q[2];
    assign spissb      = desel_q[0];
    assign sf_ce0      = desel_q[1];
    assign fpgainitb   = desel_q[2];
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized bench for spi_bus_arbiter against a cycle-level behavioural model,
// plus directed timeout and ADC/DAC alternation scenarios.
module tb_spi_bus_arbiter;

    localparam int GP = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic req_gain, req_adc, req_dac;
    logic done_gain, done_adc, done_dac;
    logic enablegain, enableadc, enabledac;
    logic spissb, sf_ce0, fpgainitb, busy, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    spi_bus_arbiter #(.GAP(GP), .TIMEOUT(TO)) dut (
        .clock(clk), .reset(rst),
        .req_gain(req_gain), .req_adc(req_adc), .req_dac(req_dac),
        .done_gain(done_gain), .done_adc(done_adc), .done_dac(done_dac),
        .enablegain(enablegain), .enableadc(enableadc), .enabledac(enabledac),
        .spissb(spissb), .sf_ce0(sf_ce0), .fpgainitb(fpgainitb),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: owner index (-1 none, 0 gain, 1 adc, 2 dac),
    // clocks held, gap clocks remaining, preferred ADC/DAC engine.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_rr    = 1;
    bit m_tmo   = 0;

    task automatic model_step(input logic [2:0] r, input logic [2:0] d, input logic rs);
        m_tmo = 0;
        if (rs) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_rr = 1;
        end else if (m_owner >= 0) begin
            bit ends = 0;
            if (d[m_owner] || !r[m_owner]) ends = 1;
            else if (m_held == TO - 1) begin ends = 1; m_tmo = 1; end
            else m_held++;
            if (ends) begin
                if (m_owner == 1) m_rr = 2;
                else if (m_owner == 2) m_rr = 1;
                m_owner = -1;
                m_gap = GP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (r != 3'b000) begin
            if (r[0]) m_owner = 0;
            else if (r[1] && r[2]) m_owner = m_rr;
            else if (r[1]) m_owner = 1;
            else m_owner = 2;
            m_held = 0;
        end
    endtask

    // Observed run tracking on the combined enables.
    bit         prev_any = 0;
    int         hi_cnt = 0, lo_cnt = 0, last_hi = 0, last_lo = 0;
    int         rises = 0, falls = 0;
    logic [2:0] rise_owner = 3'b000;
    logic       tmo_at_fall = 1'b0;

    task automatic track_clear();
        prev_any = 0; hi_cnt = 0; lo_cnt = 0; last_hi = 0; last_lo = 0;
        rises = 0; falls = 0; rise_owner = 3'b000; tmo_at_fall = 1'b0;
    endtask

    task automatic run_cycle(input logic [2:0] r, input logic [2:0] d, input logic rs);
        logic [2:0] m_en;
        logic [2:0] en_now;
        {req_dac, req_adc, req_gain}    = r;
        {done_dac, done_adc, done_gain} = d;
        rst = rs;
        @(posedge clk);
        model_step(r, d, rs);
        @(negedge clk);
        m_en = 3'b000;
        if (m_owner >= 0) m_en[m_owner] = 1'b1;
        en_now = {enabledac, enableadc, enablegain};
        chk("enables", 32'(en_now), 32'(m_en));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        chk("deselects", 32'({spissb, sf_ce0, fpgainitb}), 32'(3'b111));
        if (|en_now) begin
            if (!prev_any) begin
                last_lo = lo_cnt; rise_owner = en_now; rises++; hi_cnt = 1;
            end else hi_cnt++;
        end else begin
            if (prev_any) begin
                last_hi = hi_cnt; tmo_at_fall = timeout_err; falls++; lo_cnt = 1;
            end else lo_cnt++;
        end
        prev_any = |en_now;
    endtask

    initial begin
        logic [2:0] r, d, owner_prev;
        int falls_seen, rises_seen;

        // Reset, then idle: everything quiet, deselects high.
        run_cycle(3'b000, 3'b000, 1'b1);
        run_cycle(3'b000, 3'b000, 1'b1);
        for (int i = 0; i < 20; i++) run_cycle(3'b000, 3'b000, 1'b0);

        // Timeout: DAC holds the bus with no done.
        run_cycle(3'b000, 3'b000, 1'b1);
        track_clear();
        falls_seen = 0; rises_seen = 0;
        for (int i = 0; i < 40; i++) begin
            run_cycle(3'b100, 3'b000, 1'b0);
            if (falls != falls_seen) begin
                falls_seen = falls;
                chk("timeout_hold_len", 32'(last_hi), 32'(TO));
                chk("timeout_pulse_at_fall", 32'(tmo_at_fall), 32'd1);
            end
            if (rises != rises_seen) begin
                rises_seen = rises;
                if (rises > 1) chk("timeout_gap_len", 32'(last_lo), 32'(GP + 1));
            end
        end

        // ADC and DAC both requesting, done on the 4th granted clock.
        run_cycle(3'b000, 3'b000, 1'b1);
        track_clear();
        falls_seen = 0; rises_seen = 0; owner_prev = 3'b100;
        for (int i = 0; i < 60; i++) begin
            d = (prev_any && hi_cnt == 4) ? {enabledac, enableadc, enablegain} : 3'b000;
            run_cycle(3'b110, d, 1'b0);
            if (rises != rises_seen) begin
                rises_seen = rises;
                chk("alt_owner", 32'(rise_owner), 32'((owner_prev == 3'b010) ? 3'b100 : 3'b010));
                owner_prev = rise_owner;
                if (rises > 1) chk("alt_gap_len", 32'(last_lo), 32'(GP + 1));
            end
            if (falls != falls_seen) begin
                falls_seen = falls;
                chk("alt_hold_len", 32'(last_hi), 32'd4);
                chk("alt_no_timeout", 32'(tmo_at_fall), 32'd0);
            end
        end

        // Randomized phases with different request/done/reset densities.
        r = 3'b000;
        for (int p = 0; p < 6; p++) begin
            int pflip, pdone, prst;
            case (p)
                0: begin pflip = 10; pdone = 10; prst = 0; end
                1: begin pflip = 40; pdone = 20; prst = 0; end
                2: begin pflip = 3;  pdone = 0;  prst = 0; end
                3: begin pflip = 15; pdone = 8;  prst = 3; end
                4: begin pflip = 5;  pdone = 30; prst = 1; end
                default: begin pflip = 25; pdone = 5; prst = 2; end
            endcase
            for (int i = 0; i < 400; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if ($urandom_range(0, 99) < pflip) r[k] = ~r[k];
                    d[k] = ($urandom_range(0, 99) < pdone);
                end
                run_cycle(r, d, ($urandom_range(0, 99) < prst));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
